// File: rtl/video_ctrl_pkg.sv
// Shared types for the video capture controller: FSM state and error-code encodings.
// Also holds the width of the optional statistics counters.
package video_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StArm     = 2'd1,
      StCapture = 2'd2,
      StDone    = 2'd3
   } ctrl_state_e;

   typedef enum logic [1:0] {
      ErrNone       = 2'b00,
      ErrLineLen    = 2'b01,
      ErrShortFrame = 2'b10,
      ErrCfg        = 2'b11
   } err_code_e;

   localparam int unsigned StatsW = 16;

endpackage

// File: rtl/video_line_checker.sv
// Per-frame beat/line counting for the capture controller.
// Flags line-length mismatches and the end-of-line that completes the frame.
module video_line_checker #(
   parameter int unsigned CNT_W = 12
) (
   input  logic             axi_clk_i,
   input  logic             axi_rst_i,
   input  logic             clear_i,
   input  logic             active_i,
   input  logic             beat_i,
   input  logic             eol_i,
   input  logic [CNT_W-1:0] exp_pixels_i,
   input  logic [CNT_W-1:0] exp_lines_i,
   output logic             len_err_o,
   output logic             last_line_o
);

   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
   logic [CNT_W-1:0] beat_sum;
   logic [CNT_W:0]   line_next;

   always_comb begin
      // Beat count including a beat in the current cycle, saturating.
      beat_sum = beat_cnt_q;
      if (beat_i && (beat_cnt_q != '1)) begin
         beat_sum = beat_cnt_q + 1'b1;
      end
      line_next   = {1'b0, line_cnt_q} + 1'b1;
      len_err_o   = active_i && eol_i && (beat_sum != exp_pixels_i);
      last_line_o = active_i && eol_i && (line_next == {1'b0, exp_lines_i});

      beat_cnt_d = beat_cnt_q;
      line_cnt_d = line_cnt_q;
      if (clear_i) begin
         beat_cnt_d = '0;
         line_cnt_d = '0;
      end else if (active_i) begin
         if (eol_i) begin
            beat_cnt_d = '0;
            line_cnt_d = line_next[CNT_W-1:0];
         end else begin
            beat_cnt_d = beat_sum;
         end
      end
   end

   always_ff @(posedge axi_clk_i or posedge axi_rst_i) begin
      if (axi_rst_i) begin
         beat_cnt_q <= '0;
         line_cnt_q <= '0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         line_cnt_q <= line_cnt_d;
      end
   end

endmodule

// File: rtl/video_capture_ctrl.sv
// Frame capture controller: arms on start, decimates frames, gates one frame per capture.
// Optional frame/drop statistics enabled by defining VIDEO_CAPTURE_CTRL_STATS_EN.
module video_capture_ctrl
   import video_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 12,
   parameter int unsigned DEC_W = 4
) (
   input  logic              axi_clk_i,
   input  logic              axi_rst_i,
   input  logic              cfg_start_i,
   input  logic              cfg_stop_i,
   input  logic              cfg_continuous_i,
   input  logic [DEC_W-1:0]  cfg_decimate_i,
   input  logic [CNT_W-1:0]  cfg_exp_lines_i,
   input  logic [CNT_W-1:0]  cfg_exp_pixels_i,
   input  logic              sof_i,
   input  logic              eol_i,
   input  logic              pix_valid_i,
   input  logic              pix_ready_i,
   input  logic              dma_busy_i,
   output logic              rx_enable_o,
   output logic              stream_gate_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [1:0]        err_code_o,
   input  logic              irq_clr_i,
   output logic              irq_o
`ifdef VIDEO_CAPTURE_CTRL_STATS_EN
   ,
   output logic [StatsW-1:0] frame_cnt_o,
   output logic [StatsW-1:0] drop_cnt_o
`endif
);

   ctrl_state_e      state_q, state_d;
   logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
   logic [DEC_W-1:0] dec_q, dec_d;
   logic [CNT_W-1:0] exp_lines_q, exp_lines_d;
   logic [CNT_W-1:0] exp_pixels_q, exp_pixels_d;
   logic             cont_q, cont_d;
   logic             stop_pend_q, stop_pend_d;
   logic             err_q;
   err_code_e        err_code_q;
   logic             irq_q;

   logic             start_ok;
   logic             sof_take;
   logic             err_set;
   err_code_e        err_new;
   logic             beat;
   logic             len_err;
   logic             last_line;

   assign beat = pix_valid_i && pix_ready_i;

   video_line_checker #(
      .CNT_W (CNT_W)
   ) u_line_checker (
      .axi_clk_i    (axi_clk_i),
      .axi_rst_i    (axi_rst_i),
      .clear_i      (sof_take),
      .active_i     (state_q == StCapture),
      .beat_i       (beat),
      .eol_i        (eol_i),
      .exp_pixels_i (exp_pixels_q),
      .exp_lines_i  (exp_lines_q),
      .len_err_o    (len_err),
      .last_line_o  (last_line)
   );

   always_comb begin
      state_d      = state_q;
      dec_cnt_d    = dec_cnt_q;
      dec_d        = dec_q;
      exp_lines_d  = exp_lines_q;
      exp_pixels_d = exp_pixels_q;
      cont_d       = cont_q;
      stop_pend_d  = stop_pend_q;
      start_ok     = 1'b0;
      sof_take     = 1'b0;
      err_set      = 1'b0;
      err_new      = ErrNone;

      unique case (state_q)
         StIdle: begin
            if (!cfg_stop_i && cfg_start_i) begin
               if ((cfg_exp_lines_i == '0) || (cfg_exp_pixels_i == '0)) begin
                  err_set = 1'b1;
                  err_new = ErrCfg;
               end else begin
                  start_ok     = 1'b1;
                  dec_d        = cfg_decimate_i;
                  exp_lines_d  = cfg_exp_lines_i;
                  exp_pixels_d = cfg_exp_pixels_i;
                  cont_d       = cfg_continuous_i;
                  dec_cnt_d    = '0;
                  stop_pend_d  = 1'b0;
                  state_d      = StArm;
               end
            end
         end
         StArm: begin
            if (cfg_stop_i) begin
               state_d = StIdle;
            end else if (sof_i) begin
               dec_cnt_d = (dec_cnt_q == dec_q) ? '0 : dec_cnt_q + 1'b1;
               if ((dec_cnt_q == '0) && !dma_busy_i) begin
                  sof_take = 1'b1;
                  state_d  = StCapture;
               end
            end
         end
         StCapture: begin
            if (cfg_stop_i) begin
               stop_pend_d = 1'b1;
            end
            if (len_err) begin
               err_set = 1'b1;
               err_new = ErrLineLen;
            end
            // The completing eol wins over a same-cycle sof.
            if (last_line) begin
               state_d = StDone;
            end else if (sof_i) begin
               err_set = 1'b1;
               err_new = ErrShortFrame;
               state_d = StDone;
            end
         end
         StDone: begin
            stop_pend_d = 1'b0;
            state_d     = (cont_q && !stop_pend_q && !cfg_stop_i) ? StArm : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge axi_clk_i or posedge axi_rst_i) begin
      if (axi_rst_i) begin
         state_q      <= StIdle;
         dec_cnt_q    <= '0;
         dec_q        <= '0;
         exp_lines_q  <= '0;
         exp_pixels_q <= '0;
         cont_q       <= 1'b0;
         stop_pend_q  <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= ErrNone;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         dec_cnt_q    <= dec_cnt_d;
         dec_q        <= dec_d;
         exp_lines_q  <= exp_lines_d;
         exp_pixels_q <= exp_pixels_d;
         cont_q       <= cont_d;
         stop_pend_q  <= stop_pend_d;
         if (err_set) begin
            err_q      <= 1'b1;
            err_code_q <= err_new;
         end else if (start_ok) begin
            err_q <= 1'b0;
         end
         if (done_o || err_set) begin
            irq_q <= 1'b1;
         end else if (irq_clr_i) begin
            irq_q <= 1'b0;
         end
      end
   end

   assign rx_enable_o   = (state_q != StIdle);
   assign busy_o        = (state_q != StIdle);
   assign stream_gate_o = (state_q == StCapture);
   assign done_o        = (state_q == StDone);
   assign err_o         = err_q;
   assign err_code_o    = err_code_q;
   assign irq_o         = irq_q;

`ifdef VIDEO_CAPTURE_CTRL_STATS_EN
   logic              drop;
   logic [StatsW-1:0] frame_cnt_q;
   logic [StatsW-1:0] drop_cnt_q;

   assign drop = (state_q == StArm) && !cfg_stop_i && sof_i && (dec_cnt_q == '0) && dma_busy_i;

   always_ff @(posedge axi_clk_i or posedge axi_rst_i) begin
      if (axi_rst_i) begin
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (done_o) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
         end
         if (drop) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
         end
      end
   end

   assign frame_cnt_o = frame_cnt_q;
   assign drop_cnt_o  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_video_capture_ctrl.sv
// Directed bench for video_capture_ctrl: single-shot, decimation, errors, stop, drop, reset.
module tb_video_capture_ctrl;

   localparam int unsigned CntW = 12;
   localparam int unsigned DecW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            cfg_start, cfg_stop, cfg_cont;
   logic [DecW-1:0] cfg_dec;
   logic [CntW-1:0] cfg_lines, cfg_pixels;
   logic            sof, eol, pv, pr, dma_busy, irq_clr;
   logic            rx_enable, gate, busy, done, err, irq;
   logic [1:0]      err_code;
`ifdef VIDEO_CAPTURE_CTRL_STATS_EN
   logic [15:0]     frame_cnt, drop_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   video_capture_ctrl #(
      .CNT_W (CntW),
      .DEC_W (DecW)
   ) dut (
      .axi_clk_i        (clk),
      .axi_rst_i        (rst),
      .cfg_start_i      (cfg_start),
      .cfg_stop_i       (cfg_stop),
      .cfg_continuous_i (cfg_cont),
      .cfg_decimate_i   (cfg_dec),
      .cfg_exp_lines_i  (cfg_lines),
      .cfg_exp_pixels_i (cfg_pixels),
      .sof_i            (sof),
      .eol_i            (eol),
      .pix_valid_i      (pv),
      .pix_ready_i      (pr),
      .dma_busy_i       (dma_busy),
      .rx_enable_o      (rx_enable),
      .stream_gate_o    (gate),
      .busy_o           (busy),
      .done_o           (done),
      .err_o            (err),
      .err_code_o       (err_code),
      .irq_clr_i        (irq_clr),
      .irq_o            (irq)
`ifdef VIDEO_CAPTURE_CTRL_STATS_EN
      ,
      .frame_cnt_o      (frame_cnt),
      .drop_cnt_o       (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One line: a stall cycle, then n beats with eol on the last beat.
   task automatic line(input int n);
      pv = 1'b1; pr = 1'b0; tick();
      for (int i = 0; i < n; i++) begin
         pv = 1'b1; pr = 1'b1; eol = (i == n - 1);
         tick();
      end
      pv = 1'b0; pr = 1'b0; eol = 1'b0;
   endtask

   task automatic pulse_sof();
      sof = 1'b1; tick(); sof = 1'b0;
   endtask

   task automatic start(input logic cont, input int dec, input int lines, input int pixels);
      cfg_cont = cont; cfg_dec = DecW'(dec);
      cfg_lines = CntW'(lines); cfg_pixels = CntW'(pixels);
      cfg_start = 1'b1; tick(); cfg_start = 1'b0;
   endtask

   task automatic clear_irq();
      irq_clr = 1'b1; tick(); irq_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_cont = 1'b0; cfg_dec = '0;
      cfg_lines = '0; cfg_pixels = '0; sof = 1'b0; eol = 1'b0; pv = 1'b0; pr = 1'b0;
      dma_busy = 1'b0; irq_clr = 1'b0;
      tick(); tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rx_enable", 32'(rx_enable), 32'd0);
      check("rst_gate", 32'(gate), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      rst = 1'b0; tick();

      // Single shot, 4 lines x 8 beats; cfg changes after start must be ignored.
      start(1'b0, 0, 4, 8);
      check("t1_arm_busy", 32'(busy), 32'd1);
      check("t1_arm_gate", 32'(gate), 32'd0);
      cfg_pixels = 12'd3; cfg_lines = 12'd9;
      pulse_sof();
      check("t1_gate_after_sof", 32'(gate), 32'd1);
      for (int l = 0; l < 4; l++) line(8);
      check("t1_done", 32'(done), 32'd1);
      check("t1_done_gate", 32'(gate), 32'd0);
      tick();
      check("t1_done_one_cycle", 32'(done), 32'd0);
      check("t1_idle", 32'(busy), 32'd0);
      check("t1_err", 32'(err), 32'd0);
      check("t1_irq", 32'(irq), 32'd1);
      clear_irq();
      check("t1_irq_clr", 32'(irq), 32'd0);

      // Zero expected lines: start ignored with CFG error.
      start(1'b0, 0, 0, 8);
      check("cfg_idle", 32'(busy), 32'd0);
      check("cfg_err", 32'(err), 32'd1);
      check("cfg_code", 32'(err_code), 32'd3);
      check("cfg_irq", 32'(irq), 32'd1);
      clear_irq();
      // Stop beats same-cycle start.
      cfg_stop = 1'b1; start(1'b0, 0, 1, 2); cfg_stop = 1'b0;
      check("stop_prio_idle", 32'(busy), 32'd0);

      // Continuous, decimate 2: frames 0 and 3 of six captured.
      start(1'b1, 2, 1, 2);
      check("t2_err_cleared", 32'(err), 32'd0);
      for (int f = 0; f < 6; f++) begin
         pulse_sof();
         check($sformatf("t2_gate_f%0d", f), 32'(gate), (f == 0 || f == 3) ? 32'd1 : 32'd0);
         line(2);
         check($sformatf("t2_done_f%0d", f), 32'(done), (f == 0 || f == 3) ? 32'd1 : 32'd0);
         tick();
         check($sformatf("t2_arm_f%0d", f), 32'(busy), 32'd1);
      end
      cfg_stop = 1'b1; tick(); cfg_stop = 1'b0;
      check("t2_stop_idle", 32'(busy), 32'd0);
      clear_irq();

      // Line 2 short by one beat.
      start(1'b0, 0, 4, 8);
      pulse_sof();
      line(8); line(7);
      check("t3_err", 32'(err), 32'd1);
      check("t3_code", 32'(err_code), 32'd1);
      check("t3_irq", 32'(irq), 32'd1);
      line(8); line(8);
      check("t3_done", 32'(done), 32'd1);
      tick();
      check("t3_err_sticky", 32'(err), 32'd1);

      // sof after two of four lines.
      start(1'b0, 0, 4, 8);
      check("t4_err_cleared", 32'(err), 32'd0);
      pulse_sof();
      line(8); line(8);
      pulse_sof();
      check("t4_done", 32'(done), 32'd1);
      check("t4_code", 32'(err_code), 32'd2);
      tick();
      check("t4_idle", 32'(busy), 32'd0);

      // Drop on dma_busy, then stop mid-capture in continuous mode.
      start(1'b1, 0, 2, 4);
      dma_busy = 1'b1; pulse_sof(); dma_busy = 1'b0;
      check("t5_drop_gate", 32'(gate), 32'd0);
      check("t5_drop_arm", 32'(busy), 32'd1);
`ifdef VIDEO_CAPTURE_CTRL_STATS_EN
      check("t5_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
      pulse_sof();
      check("t5_gate", 32'(gate), 32'd1);
      line(4);
      cfg_stop = 1'b1; tick(); cfg_stop = 1'b0;
      check("t5_stop_gate", 32'(gate), 32'd1);
      line(4);
      check("t5_done", 32'(done), 32'd1);
      tick();
      check("t5_idle", 32'(busy), 32'd0);
`ifdef VIDEO_CAPTURE_CTRL_STATS_EN
      check("t5_frame_cnt", 32'(frame_cnt), 32'd6);
`endif

      // Asynchronous reset mid-line.
      start(1'b1, 0, 4, 8);
      pulse_sof();
      pv = 1'b1; pr = 1'b1; tick(); tick(); tick();
      check("t6_pre_gate", 32'(gate), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_gate", 32'(gate), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_rx", 32'(rx_enable), 32'd0);
      check("t6_rst_done", 32'(done), 32'd0);
      check("t6_rst_err", 32'(err), 32'd0);
      check("t6_rst_code", 32'(err_code), 32'd0);
      check("t6_rst_irq", 32'(irq), 32'd0);
`ifdef VIDEO_CAPTURE_CTRL_STATS_EN
      check("t6_rst_frame_cnt", 32'(frame_cnt), 32'd0);
`endif
      pv = 1'b0; pr = 1'b0;
      tick(); rst = 1'b0; tick();
      check("t6_post_idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
